// File: rtl/riscv_ctrl_pkg.sv
// Shared types and codes for the multicycle RV32I control path: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JUMP     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALRADR  = 4'd11,
    S_LUI      = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and the instruction function fields
// onto the ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      default: begin
        case (i_funct3)
          // funct7b5 only means sub for register-register ops; addi ignores it
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch, decode and
// per-class execute/writeback steps, one datapath step per clock.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_pc_update;
  logic       w_branch;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_alu_op    = ALUOP_ADD;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    RegWrite    = 1'b0;
    Illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_pc_update = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECUTER;
          OP_IMM:            w_next = S_EXECUTEI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JUMP;
          OP_JALR:           w_next = S_JALRADR;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR, S_JALRADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (r_state == S_JALRADR) w_next = S_JUMP;
        else if (op == OP_LOAD)   w_next = S_MEMREAD;
        else                      w_next = S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        w_alu_op = ALUOP_FUNC;
        w_next   = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ALUWB;
      end
      S_JUMP: begin
        // PC takes the target in ALUOut while the ALU forms the link value
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_ILLEGAL: begin
        Illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset presents the FETCH selects with every strobe held off
    if (reset) begin
      w_alu_op    = ALUOP_ADD;
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      AdrSrc      = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      ResultSrc   = RES_ALURESULT;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_FOUR;
      RegWrite    = 1'b0;
      Illegal     = 1'b0;
    end
  end

  assign PCWrite = w_pc_update | (w_branch & (Zero ^ funct3[0]));

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

endmodule
